mtr_drv: RTL

Motor-drive output stage, the consumer of the PID block's `lft_spd`/`rght_spd` outputs. It converts each signed 11-bit speed command into a complementary, non-overlapping PWM pair for the left and right H-bridges. Both channels share one free-running 11-bit PWM counter. Duty updates are double-buffered so they only take effect at period boundaries.

---
 rtl/mtr_drv_pkg.sv | 18 +
 rtl/pwm_nonovl.sv | 68 ++++++
 rtl/mtr_drv.sv | 65 ++++++
 3 files changed

// File: rtl/mtr_drv_pkg.sv
// Shared constants and types for the motor-drive PWM output stage.
// Holds counter width, stop duty, default dead time and the non-overlap FSM states.
// Also provides the signed-speed to unsigned-duty mapping helper.
package mtr_drv_pkg;

   localparam int               CNT_W         = 11;
   localparam logic [CNT_W-1:0] DUTY_STOP     = 11'h400;
   localparam int               DEAD_CYC_DFLT = 32;

   typedef enum logic [1:0] {DEAD, DRV_HI, DRV_LO} nonovl_state_t;

   // Adding 0x400 mod 2048 is the same as flipping the sign bit:
   // -1024 -> 0, 0 -> 1024, +1023 -> 2047. Every input is a legal duty.
   function automatic logic [CNT_W-1:0] spd2duty(input logic [CNT_W-1:0] spd);
      return {~spd[CNT_W-1], spd[CNT_W-2:0]};
   endfunction

endpackage

// File: rtl/pwm_nonovl.sv
// Non-overlapping complementary drive pair generated from one raw PWM compare bit.
// Latency: old drive drops 1 cycle after a raw edge, new drive rises DEAD_CYC+1 cycles after it.
// No backpressure; a raw toggle during dead time restarts the dead-time count.
module pwm_nonovl
   import mtr_drv_pkg::*;
#(
   parameter int DEAD_CYC = DEAD_CYC_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic PWM1,
   output logic PWM2
);

   localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);

   nonovl_state_t state;
   logic          raw_q;
   logic [7:0]    dcnt;

   // Dead-time FSM; outputs are registered alongside the state so both drives are never high together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= DEAD;
         raw_q <= 1'b0;
         dcnt  <= 8'd0;
         PWM1  <= 1'b0;
         PWM2  <= 1'b0;
      end else if (raw != raw_q) begin
         // Any edge of the compare bit kills both drives and restarts dead time.
         raw_q <= raw;
         dcnt  <= 8'd0;
         state <= DEAD;
         PWM1  <= 1'b0;
         PWM2  <= 1'b0;
      end else begin
         case (state)
            DEAD: begin
               if (dcnt == DEAD_LAST) begin
                  state <= raw_q ? DRV_HI : DRV_LO;
                  PWM1  <= raw_q;
                  PWM2  <= ~raw_q;
               end else begin
                  dcnt <= dcnt + 8'd1;
                  PWM1 <= 1'b0;
                  PWM2 <= 1'b0;
               end
            end
            DRV_HI: begin
               PWM1 <= 1'b1;
               PWM2 <= 1'b0;
            end
            DRV_LO: begin
               PWM1 <= 1'b0;
               PWM2 <= 1'b1;
            end
            default: begin
               state <= DEAD;
               dcnt  <= 8'd0;
               PWM1  <= 1'b0;
               PWM2  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mtr_drv.sv
// Motor-drive output stage: signed speed commands to complementary dead-timed PWM pairs.
// Latency: duties latch at the period wrap (cnt == 2047) and take effect from cnt == 0.
// No backpressure; speed inputs are sampled only at the wrap, mid-period changes wait.
module mtr_drv
   import mtr_drv_pkg::*;
#(
   parameter int DEAD_CYC = DEAD_CYC_DFLT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] lft_spd,
   input  logic [CNT_W-1:0] rght_spd,
   output logic             lftPWM1,
   output logic             lftPWM2,
   output logic             rghtPWM1,
   output logic             rghtPWM2,
   output logic             pwm_sync
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] duty_sh_l;
   logic [CNT_W-1:0] duty_sh_r;
   logic             raw_l;
   logic             raw_r;

   // Free-running period counter, double-buffered duties and the registered wrap pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         duty_sh_l <= DUTY_STOP;
         duty_sh_r <= DUTY_STOP;
         pwm_sync  <= 1'b0;
      end else begin
         cnt      <= cnt + 11'd1;
         // Registered one cycle early so the pulse lines up with cnt == 2047.
         pwm_sync <= (cnt == CNT_MAX - 11'd1);
         if (cnt == CNT_MAX) begin
            duty_sh_l <= spd2duty(lft_spd);
            duty_sh_r <= spd2duty(rght_spd);
         end
      end
   end

   assign raw_l = (cnt < duty_sh_l);
   assign raw_r = (cnt < duty_sh_r);

   pwm_nonovl #(.DEAD_CYC(DEAD_CYC)) u_lft (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_l),
      .PWM1 (lftPWM1),
      .PWM2 (lftPWM2)
   );

   pwm_nonovl #(.DEAD_CYC(DEAD_CYC)) u_rght (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_r),
      .PWM1 (rghtPWM1),
      .PWM2 (rghtPWM2)
   );

endmodule
